// File: rtl/ifid_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package ifid_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/instr_fifo.sv
// Circular buffer of fetch packets with a separate occupancy counter and a
// synchronous clear that wins over push and pop.
module instr_fifo
    import ifid_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  fetch_pkt_t    push_data,
    input  logic          pop,
    output fetch_pkt_t    head,
    output logic [CW-1:0] count
);

    fetch_pkt_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: the storage array is deliberately left out of reset; count gates
    // every read, so stale words are never observed and the array maps to RAM.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifid_queue.sv
// Fetch/decode instruction queue: pairs each issued PC with the memory word
// returned a cycle later, buffers the pairs, and applies back-pressure and flush.
module ifid_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = ifid_pkg::NOP_INSTR,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic [31:0]   pc_in,
    input  logic [31:0]   instr_in,
    input  logic          flush,
    output logic          stall_fetch,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_instr,
    output logic [CW-1:0] count
);

    logic                 pend_v;
    logic [31:0]          pend_pc;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [CW:0]          occupancy;
    ifid_pkg::fetch_pkt_t pend_pkt;
    ifid_pkg::fetch_pkt_t head;

    // The in-flight request is counted but a same-cycle pop is not, so a
    // returning word always finds a free slot.
    assign occupancy   = {1'b0, count} + {{CW{1'b0}}, pend_v};
    assign stall_fetch = occupancy >= (CW + 1)'(DEPTH);

    assign accept = fetch_req && !stall_fetch && !flush;
    assign push   = pend_v && !flush;
    assign pop    = id_valid && id_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v  <= 1'b0;
            pend_pc <= '0;
        end else begin
            pend_v <= accept;
            if (accept) begin
                pend_pc <= pc_in;
            end
        end
    end

    assign pend_pkt = '{pc: pend_pc, instr: instr_in};

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (pend_pkt),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign id_valid = (count != '0);
    assign id_pc    = id_valid ? head.pc    : '0;
    assign id_instr = id_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_ifid_queue.sv
// Scoreboard bench for ifid_queue: stimulus queues expected pairs, a negedge
// monitor pops and compares every handshake; directed checks cover timing.
module tb_ifid_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        flush;
    logic        stall_fetch;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [2:0]  count;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mem_req;
    logic [31:0] mem_pc;

    ifid_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .flush       (flush),
        .stall_fetch (stall_fetch),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: distinct word per PC; 0x0/0x4/0x8 give addi x1..x3.
    function automatic logic [31:0] instr_for(input logic [31:0] pc);
        logic [7:0] k;
        k = pc[9:2] + 8'd1;
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    // One cycle of inputs; the synchronous memory answers last cycle's request.
    task automatic drive(input logic req, input logic [31:0] pc, input logic rdy,
                         input logic fl, input logic acc);
        instr_in  = mem_req ? instr_for(mem_pc) : 32'hDEAD_BEEF;
        mem_req   = req;
        mem_pc    = pc;
        fetch_req = req;
        pc_in     = pc;
        id_ready  = rdy;
        flush     = fl;
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back('{pc, instr_for(pc)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready && !flush) begin
            check("sb_expected_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("sb_pc", id_pc, mon_e.pc);
                check("sb_instr", id_instr, mon_e.instr);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(dut.push && dut.count == 3'(DEPTH)))
        else $error("push into full queue");
    assert property (@(posedge clk) disable iff (!rst_n) !(dut.pop && dut.count == 3'd0))
        else $error("pop from empty queue");

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  rdy_pat;
        logic [15:0] stall_pat;
        logic        req;
        logic        acc;
        int          idx;

        rst_n   = 1'b0;
        mem_req = 1'b0;
        mem_pc  = '0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(id_valid), 0);
        check("rst_pc", id_pc, 0);
        check("rst_instr", id_instr, 32'h0000_0013);
        check("rst_stall", 32'(stall_fetch), 0);
        rst_n = 1'b1;
        tick();

        // Back-to-back fetch with decode always ready.
        drive(1, 32'h0, 1, 0, 1); #1 check("t1_valid_c0", 32'(id_valid), 0); tick();
        drive(1, 32'h4, 1, 0, 1); #1 check("t1_valid_c1", 32'(id_valid), 0); tick();
        drive(1, 32'h8, 1, 0, 1); #1 check("t1_valid_c2", 32'(id_valid), 1);
        check("t1_first_instr", id_instr, 32'h0010_0093); check("t1_count_c2", 32'(count), 1); tick();
        drive(0, 0, 1, 0, 0); #1 check("t1_count_c3", 32'(count), 1); tick();
        drive(0, 0, 1, 0, 0); #1 check("t1_count_c4", 32'(count), 1); tick();
        drive(0, 0, 1, 0, 0); #1 check("t1_count_c5", 32'(count), 0); tick();

        // Decode blocked: fill, saturate, then pop while fetch is blocked.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i * 4), 0, 0, 1); #1 check("t2_stall_fill", 32'(stall_fetch), 0); tick();
        end
        drive(1, 32'h10, 0, 0, 0); #1 check("t2_stall_set", 32'(stall_fetch), 1);
        check("t2_count3", 32'(count), 3); tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h10, 0, 0, 0); #1 check("t2_count_sat", 32'(count), 4);
            check("t2_stall_held", 32'(stall_fetch), 1); tick();
        end
        drive(1, 32'h10, 1, 0, 0); #1 check("t3_count_pop_cycle", 32'(count), 4);
        check("t3_stall_pop_cycle", 32'(stall_fetch), 1); tick();
        drive(0, 0, 1, 0, 0); #1 check("t3_count_after_pop", 32'(count), 3);
        check("t3_stall_released", 32'(stall_fetch), 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0); tick();
        end
        check("t2_drained", 32'(count), 0);

        // Flush with three queued, one in flight and a request in the same cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100 + 32'(i * 4), 0, 0, 1); tick();
        end
        drive(1, 32'h110, 1, 1, 0); #1 check("t4_count_pre", 32'(count), 3); tick();
        drive(1, 32'h40, 1, 0, 1); #1
        check("t4_count_flushed", 32'(count), 0);
        check("t4_valid_flushed", 32'(id_valid), 0);
        check("t4_instr_nop", id_instr, 32'h0000_0013);
        check("t4_pc_zero", id_pc, 0);
        check("t4_stall_clear", 32'(stall_fetch), 0); tick();
        drive(0, 0, 1, 0, 0); #1 check("t4_no_stale_push", 32'(id_valid), 0); tick();
        drive(0, 0, 1, 0, 0); #1 check("t4_new_path_pc", id_pc, 32'h40);
        check("t4_new_path_valid", 32'(id_valid), 1); tick();

        // Wrap-around with intermittent ready; fetch holds its PC when stalled.
        rdy_pat   = 5'b01101;
        stall_pat = 16'h1480;
        idx       = 0;
        for (int k = 0; k < 15; k++) begin
            req = (idx < 10);
            acc = req && !stall_pat[k];
            drive(req, 32'h200 + 32'(idx * 4), rdy_pat[k % 5], 0, acc);
            #1 check("t5_stall", 32'(stall_fetch), 32'(stall_pat[k]));
            if (acc) idx++;
            tick();
        end
        for (int w = 0; w < 8 && count != 0; w++) begin
            drive(0, 0, 1, 0, 0); tick();
        end
        check("t5_drained", 32'(count), 0);
        check("t5_all_seen", 32'(exp_q.size()), 0);

        // Asynchronous reset with two entries queued.
        drive(1, 32'h300, 0, 0, 1); tick();
        drive(1, 32'h304, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); #1 check("t6_count_pre", 32'(count), 2);
        rst_n = 1'b0;
        exp_q.delete();
        #1
        check("t6_count_rst", 32'(count), 0);
        check("t6_valid_rst", 32'(id_valid), 0);
        check("t6_pc_rst", id_pc, 0);
        check("t6_instr_rst", id_instr, 32'h0000_0013);
        check("t6_stall_rst", 32'(stall_fetch), 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0); #1 check("t6_no_stale", 32'(id_valid), 0); tick();
        end
        drive(1, 32'h308, 1, 0, 1); tick();
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 1, 0, 0); #1 check("t6_resume_valid", 32'(id_valid), 1); tick();
        drive(0, 0, 1, 0, 0); tick();
        check("final_all_seen", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifid_queue.md
# ifid_queue

Instruction queue between the fetch stage and decode. Pairs each issued fetch PC with the instruction word returned one cycle later by the synchronous instruction-memory banks, then buffers the pairs in a small FIFO. Decode consumes the pairs through a valid/ready handshake. Provides fetch back-pressure and a single-cycle flush for taken branches.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- NOP_INSTR, 32'h0000_0013: word driven on id_instr when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock. One clock domain.
- rst_n  input  1  reset. Asynchronous assertion, active-low.
- fetch_req  input  1  pc_in is being issued to instruction memory this cycle (memory read enabled).
- pc_in  input  32  address being issued.
- instr_in  input  32  memory read data; valid the cycle after the matching fetch_req.
- flush  input  1  taken branch or jump; kill all queued and in-flight instructions.
- stall_fetch  output  1  fetch must hold its PC and not issue; combinational.
- id_valid  output  1  head entry valid for decode.
- id_ready  input  1  decode accepts head this cycle.
- id_pc  output  32  PC of head entry.
- id_instr  output  32  instruction of head entry, or NOP_INSTR when empty.
- count  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- Accept rule: a request is accepted when fetch_req && !stall_fetch && !flush.
- Pending stage: on an accepted request, register pc_in into pend_pc and set pend_v. Otherwise clear pend_v.
- Push: when pend_v && !flush, write {pend_pc, instr_in} at the write pointer.
- Pop: when id_valid && id_ready && !flush, advance the read pointer.
- Back-pressure: stall_fetch = (count + pend_v) >= DEPTH.
  - Pops are ignored in this term (conservative), so a push can never find the FIFO full.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. count is a separate counter.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: count unchanged, both pointers advance. This is legal at count==DEPTH−1 and at count==1.
- Outputs:
  - id_valid = (count != 0).
  - id_pc and id_instr come from the head entry.
  - When empty: id_pc = 0, id_instr = NOP_INSTR.
- Flush:
  - Next edge: count=0, both pointers=0, pend_v=0.
  - A fetch_req and any instr_in arriving in the flush cycle are discarded.
  - The first request accepted in the cycle after flush belongs to the new path.
- Error: push with count==DEPTH, or pop with count==0, is a design error. The bench checks these with assertions; the RTL has no recovery path for them.

## Timing
- Reset values: count=0, pointers=0, pend_v=0, id_valid=0, id_pc=0, id_instr=NOP_INSTR, stall_fetch=0.
- Storage array is not reset.
- Reset asserted mid-operation: the queue empties immediately (asynchronous reset). Outputs return to reset values in the same cycle.
- Latency: request accepted in cycle N → instr_in sampled in N+1 → id_valid and head data visible in N+2. Minimum fetch-to-decode latency is 2 cycles.
- Throughput: 1 instruction/cycle sustained when id_ready is held high. Steady-state occupancy is 1 with pend_v=1.
- stall_fetch becomes 1 in the same cycle that count + pend_v reaches DEPTH. It deasserts the cycle after a pop brings the sum below DEPTH.
- flush takes priority over push, pop and accept in the same cycle. id_valid=0 in cycle N+1 after flush in cycle N.

## Structure
- Package ifid_pkg:
  - fetch_pkt_t struct {logic [31:0] pc; logic [31:0] instr;}
  - NOP_INSTR constant
- Sub-module instr_fifo:
  - Parameterised DEPTH storage of fetch_pkt_t, with pointers, count, push/pop/clear.
  - The top level holds the pending stage, accept/stall logic and flush gating.

## Test plan
- Reset, then reqs at PC 0x0, 0x4, 0x8 on consecutive cycles with instr_in = 0x00100093, 0x00200113, 0x00300193 one cycle later and id_ready=1 → id_valid rises 2 cycles after the first req; decode sees the pairs in order; count ≤1.
- id_ready=0, continuous fetch_req → stall_fetch=1 once count+pend_v=4; count saturates at 4; no entry lost. Release id_ready → entries drain in PC order 0x0..0xC.
- Full queue: pop and a blocked request in the same cycle → count stays 4 for one cycle then falls. stall_fetch deasserts the cycle after the pop.
- count=3, pend_v=1, flush=1 with fetch_req=1 → next cycle count=0, id_valid=0, id_instr=0x00000013, pend_v=0. Req at 0x40 in the following cycle → appears at id_pc=0x40 two cycles later.
- Wrap-around: push 10 entries with intermittent id_ready (1,0,1,1,0…) → pointers wrap past 3; the output order matches the input order.
- rst_n asserted low while count=2 → outputs at reset values immediately; no stale entry appears after release.
